perf_counter_bank: RTL and testbench
====================================

Name: perf_counter_bank

Overview:
Synthesizable, parametrised performance-counter bank for the pipelined cache CPU. Counts per-cycle event strobes (instructions retired, I/D cache requests and hits, and similar) and keeps a free-running cycle count with a watchdog limit. Freezes all counts on halt and offers a registered readout port. On-chip successor to the simulation-only statistics logic: configurable channel count, counter width, and wrap/saturate mode, with stall gating, clear, and a timeout state.

Parameters:
NUM_EVENTS, 6, number of event channels.
CNT_W, 32, width of every counter, including the cycle counter.
SATURATE, 1, 1 = counters stick at all-ones on overflow; 0 = counters wrap to 0.
WDOG_LIMIT, 100000, cycle count at which TIMEOUT is entered; 0 disables the watchdog.
SEL_W, $clog2(NUM_EVENTS+1), readout select width (derived; do not override).

Ports:
clk  in  1  clock.
rst_n  in  1  synchronous active-low reset.
start  in  1  single-cycle pulse: IDLE -> RUN.
clear  in  1  zero all counters and overflow flags.
stall  in  1  global pipeline stall; masks event counting.
halt  in  1  processor halt; freezes counts.
event_i  in  NUM_EVENTS  per-cycle event strobes, bit i -> counter i.
rd_sel  in  SEL_W  readout select: 0..NUM_EVENTS-1 = event counter; NUM_EVENTS = cycle counter.
rd_data  out  CNT_W  registered readout value.
cycle_cnt  out  CNT_W  live cycle counter.
ovf  out  NUM_EVENTS+1  sticky overflow flags; bit NUM_EVENTS belongs to the cycle counter.
running  out  1  state == RUN.
done  out  1  state == FROZEN or TIMEOUT.
timeout  out  1  state == TIMEOUT.

Behaviour:
- Reset, sampled on a clk edge with rst_n=0: state IDLE; all counters 0; ovf 0; rd_data 0. running, done and timeout are 0.
- States: IDLE, RUN, FROZEN, TIMEOUT (2-bit encoding).
- IDLE:
  - Nothing counts.
  - start=1 -> RUN on the next edge.
  - Events in the start cycle are not counted.
- RUN, every cycle:
  - cycle_cnt += 1, regardless of stall.
  - For each i with event_i[i]=1 and stall=0: counter i += 1.
- RUN -> FROZEN when halt=1. The halt-cycle increments (cycle and unstalled events) are applied on that same edge.
- RUN -> TIMEOUT when WDOG_LIMIT != 0 and the incremented cycle_cnt equals WDOG_LIMIT. cycle_cnt then reads WDOG_LIMIT. That cycle's event increments are applied.
- halt and timeout on the same edge: FROZEN wins.
- FROZEN and TIMEOUT: all counters hold; halt, start, stall and event_i are ignored.
- clear (highest priority after reset):
  - Zeroes all counters and ovf on the next edge; no increment is applied that cycle.
  - In RUN: stays RUN.
  - In FROZEN or TIMEOUT: goes to IDLE.
  - In IDLE: stays IDLE.
  - clear together with start in IDLE: clear wins and the state stays IDLE.
- Overflow, for any counter at all-ones that gets an increment:
  - SATURATE=1: counter holds all-ones.
  - SATURATE=0: counter wraps to 0.
  - Either mode: the matching ovf bit sets and stays set until clear or reset.
- Readout latency is 1 cycle:
  - rd_data at edge n+1 equals the value selected by rd_sel at edge n, taken from the pre-update counter values of cycle n.
  - rd_sel > NUM_EVENTS returns 0.
  - rd_data keeps updating in every state, including FROZEN.
- No combinational path from event_i, stall or halt to any output.

Test Plan:
1. Reset hold, then start; assert event_i[0] on 10 cycles with stall=0, then halt -> counter0 = 10, state FROZEN, done=1. Reading rd_sel=0 gives rd_data=10 one cycle later; further events do not change counter0.
2. In RUN, event_i[1]=1 for 8 cycles with stall=1 on 3 of them -> counter1 = 5; cycle_cnt advances by 8.
3. CNT_W=4, SATURATE=1, 20 events on channel 2 -> counter2 = 15 and ovf[2]=1. Same stimulus with SATURATE=0 -> counter2 = 4 and ovf[2]=1.
4. WDOG_LIMIT=50, start with no halt -> after 50 RUN cycles cycle_cnt=50, timeout=1, counts frozen. Variant: halt in the 50th cycle -> FROZEN, timeout=0.
5. clear in RUN while counter0=7 -> counter0=0 next cycle and the event in the clear cycle is not counted, state RUN. clear in FROZEN -> IDLE with all zeros.
6. rd_sel = NUM_EVENTS returns cycle_cnt delayed one cycle; rd_sel = NUM_EVENTS+1 returns 0. A synchronous reset asserted mid-RUN returns every output to its reset value.

Source files
------------

// File: rtl/perf_counter_bank.sv
// Performance-counter bank: per-channel event counters plus a cycle counter with watchdog,
// freeze-on-halt, sticky overflow flags and a one-cycle registered readout port.
module perf_counter_bank #(
  parameter int unsigned NUM_EVENTS = 6,
  parameter int unsigned CNT_W      = 32,
  parameter int unsigned SATURATE   = 1,
  parameter int unsigned WDOG_LIMIT = 100000,
  parameter int unsigned SEL_W      = $clog2(NUM_EVENTS + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  clear,
  input  logic                  stall,
  input  logic                  halt,
  input  logic [NUM_EVENTS-1:0] event_i,
  input  logic [SEL_W-1:0]      rd_sel,
  output logic [CNT_W-1:0]      rd_data,
  output logic [CNT_W-1:0]      cycle_cnt,
  output logic [NUM_EVENTS:0]   ovf,
  output logic                  running,
  output logic                  done,
  output logic                  timeout
);

  localparam int unsigned NumCnt = NUM_EVENTS + 1;
  localparam logic [CNT_W-1:0] WdogVal = CNT_W'(WDOG_LIMIT);

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StRun     = 2'd1,
    StFrozen  = 2'd2,
    StTimeout = 2'd3
  } stateT;

  stateT stateQ, stateD;

  // Entry NUM_EVENTS is the cycle counter; it shares the overflow/saturate logic.
  logic [NUM_EVENTS:0][CNT_W-1:0] cntQ, cntD;
  logic [NUM_EVENTS:0]            ovfQ, ovfD, incEn;
  logic [CNT_W-1:0]               rdDataQ, rdDataD;

  always_comb begin
    stateD = stateQ;
    cntD   = cntQ;
    ovfD   = ovfQ;
    incEn  = '0;
    if (clear) begin
      cntD = '0;
      ovfD = '0;
      if (stateQ != StRun) stateD = StIdle;
    end else begin
      unique case (stateQ)
        StIdle: begin
          if (start) stateD = StRun;
        end
        StRun: begin
          incEn = {1'b1, event_i & {NUM_EVENTS{~stall}}};
          for (int unsigned i = 0; i < NumCnt; i++) begin
            if (incEn[i]) begin
              if (&cntQ[i]) begin
                ovfD[i] = 1'b1;
                if (SATURATE == 0) cntD[i] = '0;
              end else begin
                cntD[i] = cntQ[i] + 1'b1;
              end
            end
          end
          // Halt takes precedence over a watchdog hit on the same edge.
          if (halt) begin
            stateD = StFrozen;
          end else if ((WDOG_LIMIT != 0) && (cntD[NUM_EVENTS] == WdogVal)) begin
            stateD = StTimeout;
          end
        end
        StFrozen, StTimeout: begin
        end
      endcase
    end
  end

  // Readout uses pre-update values so it reflects the counters as they stood this cycle.
  always_comb begin
    rdDataD = '0;
    for (int unsigned i = 0; i < NumCnt; i++) begin
      if (rd_sel == SEL_W'(i)) rdDataD = cntQ[i];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stateQ  <= StIdle;
      cntQ    <= '0;
      ovfQ    <= '0;
      rdDataQ <= '0;
    end else begin
      stateQ  <= stateD;
      cntQ    <= cntD;
      ovfQ    <= ovfD;
      rdDataQ <= rdDataD;
    end
  end

  assign rd_data   = rdDataQ;
  assign cycle_cnt = cntQ[NUM_EVENTS];
  assign ovf       = ovfQ;
  assign running   = (stateQ == StRun);
  assign done      = (stateQ == StFrozen) || (stateQ == StTimeout);
  assign timeout   = (stateQ == StTimeout);

endmodule

// File: tb/tb_perf_counter_bank.sv
// Directed bench: a 32-bit bank with a 50-cycle watchdog plus 4-bit saturate and wrap banks,
// all driven by the same stimulus.
module tb_perf_counter_bank;

  logic       clk;
  logic       rst_n;
  logic       start, clear, stall, halt;
  logic [5:0] event_i;
  logic [2:0] rd_sel;

  logic [31:0] mRd, mCyc;
  logic [6:0]  mOvf;
  logic        mRun, mDone, mTo;
  logic [3:0]  sRd, sCyc, wRd, wCyc;
  logic [6:0]  sOvf, wOvf;
  logic        sRun, sDone, sTo, wRun, wDone, wTo;

  int nCmp = 0;
  int nErr = 0;

  perf_counter_bank #(
    .NUM_EVENTS(6), .CNT_W(32), .SATURATE(1), .WDOG_LIMIT(50)
  ) uMain (
    .clk(clk), .rst_n(rst_n), .start(start), .clear(clear), .stall(stall), .halt(halt),
    .event_i(event_i), .rd_sel(rd_sel), .rd_data(mRd), .cycle_cnt(mCyc), .ovf(mOvf),
    .running(mRun), .done(mDone), .timeout(mTo)
  );

  perf_counter_bank #(
    .NUM_EVENTS(6), .CNT_W(4), .SATURATE(1), .WDOG_LIMIT(0)
  ) uSat (
    .clk(clk), .rst_n(rst_n), .start(start), .clear(clear), .stall(stall), .halt(halt),
    .event_i(event_i), .rd_sel(rd_sel), .rd_data(sRd), .cycle_cnt(sCyc), .ovf(sOvf),
    .running(sRun), .done(sDone), .timeout(sTo)
  );

  perf_counter_bank #(
    .NUM_EVENTS(6), .CNT_W(4), .SATURATE(0), .WDOG_LIMIT(0)
  ) uWrap (
    .clk(clk), .rst_n(rst_n), .start(start), .clear(clear), .stall(stall), .halt(halt),
    .event_i(event_i), .rd_sel(rd_sel), .rd_data(wRd), .cycle_cnt(wCyc), .ovf(wOvf),
    .running(wRun), .done(wDone), .timeout(wTo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nCmp = nCmp + 1;
    assert (obs === exp)
    else begin
      nErr = nErr + 1;
      $error("FAIL %s: observed %0d required %0d", tag, obs, exp);
    end
  endtask

  initial begin
    logic [7:0] stallPat;
    stallPat = 8'b0101_0100;
    rst_n = 1'b0; start = 1'b0; clear = 1'b0; stall = 1'b0; halt = 1'b0;
    event_i = '0; rd_sel = '0;

    // Reset state
    tick(); tick();
    chk("rst_rd", mRd, 0);
    chk("rst_cyc", mCyc, 0);
    chk("rst_ovf", 32'(mOvf), 0);
    chk("rst_run", 32'(mRun), 0);
    chk("rst_done", 32'(mDone), 0);
    chk("rst_to", 32'(mTo), 0);
    rst_n = 1'b1;

    // Start cycle event is not counted
    start = 1'b1; event_i = 6'b000001;
    tick();
    start = 1'b0;
    chk("t1_run", 32'(mRun), 1);
    chk("t1_cyc0", mCyc, 0);
    for (int k = 0; k < 10; k++) tick();
    chk("t1_cyc10", mCyc, 10);
    halt = 1'b1; event_i = '0;
    tick();
    halt = 1'b0;
    chk("t1_done", 32'(mDone), 1);
    chk("t1_frz_run", 32'(mRun), 0);
    chk("t1_cyc11", mCyc, 11);
    event_i = 6'b000001; rd_sel = 3'd0;
    tick();
    chk("t1_rd_cnt0", mRd, 10);
    tick();
    chk("t1_rd_cnt0_hold", mRd, 10);
    chk("t1_cyc_hold", mCyc, 11);
    rd_sel = 3'd6;
    tick();
    chk("t1_rd_cycle", mRd, 11);

    // Clear in FROZEN returns to IDLE with zeros
    event_i = '0; clear = 1'b1;
    tick();
    clear = 1'b0;
    chk("t5_frz_clr_done", 32'(mDone), 0);
    chk("t5_frz_clr_run", 32'(mRun), 0);
    chk("t5_frz_clr_cyc", mCyc, 0);
    rd_sel = 3'd0;
    tick();
    chk("t5_frz_clr_rd", mRd, 0);

    // Stall gating on channel 1
    start = 1'b1;
    tick();
    start = 1'b0;
    event_i = 6'b000010;
    for (int k = 0; k < 8; k++) begin
      stall = stallPat[k];
      tick();
    end
    stall = 1'b0;
    chk("t2_cyc8", mCyc, 8);
    event_i = '0; rd_sel = 3'd1;
    tick();
    chk("t2_cnt1", mRd, 5);

    // Clear in RUN with counter0 = 7
    event_i = 6'b000001;
    for (int k = 0; k < 7; k++) tick();
    chk("t5_cyc16", mCyc, 16);
    rd_sel = 3'd0; clear = 1'b1;
    tick();
    clear = 1'b0; event_i = '0;
    chk("t5_rd_pre_clr", mRd, 7);
    chk("t5_clr_cyc", mCyc, 0);
    chk("t5_clr_run", 32'(mRun), 1);
    tick();
    chk("t5_clr_cnt0", mRd, 0);
    chk("t5_clr_cyc1", mCyc, 1);

    // Synchronous reset mid-RUN
    event_i = 6'b000001;
    tick(); tick(); tick();
    chk("t6_pre_rst_rd", mRd, 2);
    rst_n = 1'b0;
    tick();
    chk("t6_rst_rd", mRd, 0);
    chk("t6_rst_cyc", mCyc, 0);
    chk("t6_rst_run", 32'(mRun), 0);
    chk("t6_rst_ovf", 32'(mOvf), 0);
    rst_n = 1'b1; event_i = '0;

    // Saturate vs wrap on 4-bit counters, 20 events on channel 2
    start = 1'b1;
    tick();
    start = 1'b0; event_i = 6'b000100;
    for (int k = 0; k < 20; k++) tick();
    chk("t3_main_cyc", mCyc, 20);
    chk("t3_sat_cyc", 32'(sCyc), 15);
    chk("t3_wrap_cyc", 32'(wCyc), 4);
    chk("t3_main_ovf", 32'(mOvf), 0);
    chk("t3_sat_ovf", 32'(sOvf), 32'h44);
    chk("t3_wrap_ovf", 32'(wOvf), 32'h44);
    event_i = '0; rd_sel = 3'd2; halt = 1'b1;
    tick();
    halt = 1'b0;
    chk("t3_main_cnt2", mRd, 20);
    chk("t3_sat_cnt2", 32'(sRd), 15);
    chk("t3_wrap_cnt2", 32'(wRd), 4);
    rd_sel = 3'd7;
    tick();
    chk("t6_sel_oob", mRd, 0);
    chk("t3_sat_done", 32'(sDone), 1);

    // Watchdog at 50 cycles
    clear = 1'b1;
    tick();
    clear = 1'b0; start = 1'b1;
    tick();
    start = 1'b0; event_i = 6'b001000;
    for (int k = 0; k < 49; k++) tick();
    chk("t4_to_early", 32'(mTo), 0);
    chk("t4_cyc49", mCyc, 49);
    tick();
    chk("t4_to", 32'(mTo), 1);
    chk("t4_to_done", 32'(mDone), 1);
    chk("t4_to_cyc", mCyc, 50);
    rd_sel = 3'd3;
    tick();
    chk("t4_to_cnt3", mRd, 50);
    chk("t4_to_cyc_hold", mCyc, 50);

    // Clear with start in IDLE: clear wins
    event_i = '0; clear = 1'b1;
    tick();
    chk("t4_clr_to_idle", 32'(mDone), 0);
    start = 1'b1;
    tick();
    clear = 1'b0;
    chk("t5_clr_start_idle", 32'(mRun), 0);
    tick();
    start = 1'b0;
    chk("t4b_run", 32'(mRun), 1);

    // Halt on the watchdog cycle: FROZEN wins
    for (int k = 0; k < 49; k++) tick();
    halt = 1'b1;
    tick();
    halt = 1'b0;
    chk("t4b_to", 32'(mTo), 0);
    chk("t4b_done", 32'(mDone), 1);
    chk("t4b_cyc", mCyc, 50);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

endmodule
